// File: rtl/req_arbiter.sv
//==============================================================================
// req_arbiter : 4-way request arbiter, registered one-hot grant, tenure limit.
// Optional macro ROUND_ROBIN_EN selects rotating priority (default: fixed 3>2>1>0).
// Revision: 1.0
//==============================================================================
`default_nettype none

module req_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_gnt_id, w_gnt_id_nxt;
  logic       r_gnt_vld, w_gnt_vld_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;

  logic [1:0] w_base;
  logic [1:0] w_cand;
  logic [1:0] w_winner;
  logic       w_found;
  logic       w_release;
  logic       w_expire;

`ifdef ROUND_ROBIN_EN
  logic [1:0] r_last_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id <= 2'd0;
    end else if (r_state == S_IDLE && w_found) begin
      r_last_id <= w_winner;
    end
  end

  assign w_base = r_last_id;
`else
  assign w_base = 2'd0;
`endif

  // Search base-1, base-2, base-3, base (mod 4); base 0 gives fixed 3,2,1,0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    w_cand   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = w_base - 2'(i);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_release = done || !req[r_gnt_id];
  assign w_expire  = (r_hold_cnt == c_hold_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_timeout_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt      = 4'b0000;
        w_gnt_vld_nxt  = 1'b0;
        w_hold_cnt_nxt = 8'd0;
        if (w_found) begin
          w_state_nxt   = S_GRANT;
          w_gnt_nxt     = 4'b0001 << w_winner;
          w_gnt_id_nxt  = w_winner;
          w_gnt_vld_nxt = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_release || w_expire) begin
          // A normal release wins over a coincident expiry: no timeout pulse.
          w_state_nxt    = S_IDLE;
          w_gnt_nxt      = 4'b0000;
          w_gnt_vld_nxt  = 1'b0;
          w_timeout_nxt  = !w_release;
          w_hold_cnt_nxt = 8'd0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_gnt_nxt     = 4'b0000;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= 4'b0000;
      r_gnt_id   <= 2'd0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;
  assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter.sv
//==============================================================================
// tb_req_arbiter : directed self-checking bench for req_arbiter (HOLD_MAX=4).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  integer checks = 0;
  integer errors = 0;

  req_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks = checks + 1;
      if (!$onehot0(gnt) || (gnt_vld !== (|gnt))) begin
        errors = errors + 1;
        $display("FAIL invariant: gnt=%b gnt_vld=%b, required onehot0 gnt and gnt_vld==|gnt", gnt, gnt_vld);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    tick(); tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset: gnt=%b vld=%b id=%0d to=%b, required 0000 0 0 0", gnt, gnt_vld, gnt_id, timeout);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL idle_no_req: gnt=%b vld=%b, required 0000 0", gnt, gnt_vld);
    end
  endtask

  task automatic test_basic();
    req = 4'b0110;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_vld !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL basic_grant: gnt=%b id=%0d vld=%b, required 0100 2 1", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0000;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL req_drop_release: gnt=%b to=%b, required 0000 0", gnt, timeout);
    end
    tick();
  endtask

  task automatic test_done_release();
    req = 4'b0010;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors = errors + 1;
      $display("FAIL grant_id1: gnt=%b id=%0d, required 0010 1", gnt, gnt_id);
    end
    req = 4'b1010;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0010) begin
      errors = errors + 1;
      $display("FAIL no_preempt: gnt=%b, required 0010", gnt);
    end
    done = 1'b1;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL done_release: gnt=%b to=%b, required 0000 0", gnt, timeout);
    end
    done = 1'b0;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors = errors + 1;
      $display("FAIL regrant_after_bubble: gnt=%b id=%0d, required 1000 3", gnt, gnt_id);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_done_in_idle();
    done = 1'b1; req = 4'b0000;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL done_idle_no_grant: gnt=%b, required 0000", gnt);
    end
    req = 4'b0100;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0100) begin
      errors = errors + 1;
      $display("FAIL done_idle_arbitrates: gnt=%b, required 0100", gnt);
    end
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL done_in_grant: gnt=%b to=%b, required 0000 0", gnt, timeout);
    end
    done = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks = checks + 1;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL hold_cycle%0d: gnt=%b to=%b, required 0001 0", i, gnt, timeout);
      end
    end
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || gnt_vld !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL expiry: gnt=%b to=%b vld=%b, required 0000 1 0", gnt, timeout, gnt_vld);
    end
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0001 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL regrant_after_timeout: gnt=%b to=%b, required 0001 0", gnt, timeout);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  // Variant 0: done on the last allowed cycle; variant 1: req drop on it.
  task automatic test_release_at_expiry();
    for (int v = 0; v < 2; v++) begin
      req = 4'b0001;
      tick(); tick(); tick(); tick();
      if (v == 0) done = 1'b1;
      else        req = 4'b0000;
      tick();
      checks = checks + 1;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL release_at_expiry v%0d: gnt=%b to=%b, required 0000 0", v, gnt, timeout);
      end
      done = 1'b0; req = 4'b0000;
      tick();
      checks = checks + 1;
      if (timeout !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL no_late_timeout v%0d: to=%b, required 0", v, timeout);
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_id [5];
`ifdef ROUND_ROBIN_EN
    exp_id = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
    exp_id = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    req = 4'b1111; done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks = checks + 1;
      if (gnt !== (4'b0001 << exp_id[k]) || gnt_id !== exp_id[k]) begin
        errors = errors + 1;
        $display("FAIL seq_grant%0d: gnt=%b id=%0d, required id %0d", k, gnt, gnt_id, exp_id[k]);
      end
      tick();
      checks = checks + 1;
      if (gnt !== 4'b0000) begin
        errors = errors + 1;
        $display("FAIL seq_bubble%0d: gnt=%b, required 0000", k, gnt);
      end
    end
    req = 4'b0000; done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b1000;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b1000) begin
      errors = errors + 1;
      $display("FAIL pre_reset_grant: gnt=%b, required 1000", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_reset: gnt=%b vld=%b to=%b, required 0000 0 0", gnt, gnt_vld, timeout);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b1000 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL regrant_after_reset: gnt=%b to=%b, required 1000 0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
    checks = checks + 1;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL final_release: gnt=%b to=%b, required 0000 0", gnt, timeout);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    test_reset();
    test_basic();
    test_done_release();
    test_done_in_idle();
    test_timeout();
    test_release_at_expiry();
    test_sequence();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
